global_pool_mc: RTL
===================

# global_pool_mc

Parametrised multi-channel global pooling engine for the CNN accelerator tail. It consumes a channel-interleaved feature-map stream of `2**LOG2_N` spatial positions by `CH` channels. It reduces each channel to one value, either the rounded average or the maximum, and drains the `CH` results through a ready/valid output port. It sits between the last conv/activation stage and the classifier.

## Interface
- `DATA_W`, 16: signed sample and result width.
- `CH`, 4: channel count (≥1).
- `LOG2_N`, 12: log2 of spatial positions per channel (1..16); 12 = 64×64 map.
- `ACC_W`, 32: accumulator width; must be ≥ `DATA_W+LOG2_N`. Elaboration error otherwise.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-low reset (0 = reset).
- `gap_en` in 1: level enable; 0→1 while IDLE starts a frame; 0 during a frame aborts it.
- `mode` in 1: 0 = average, 1 = max; sampled on frame start only.
- `in_data` in DATA_W: signed sample.
- `valid_in` in 1: sample valid.
- `ready_in` out 1: block accepts a sample; high only in ACCUM.
- `out_data` out DATA_W: signed pooled result.
- `out_ch` out clog2(CH) (min 1): channel index of `out_data`.
- `valid_out` out 1: result valid; held until accepted.
- `ready_out` in 1: downstream accepts result.
- `done` out 1: one-cycle pulse after last result accepted.
- `dbg_accumulator` out ACC_W: channel-0 accumulator.
- `dbg_sample_count` out 17: spatial positions completed in current frame.

## Operation
- Input order: position-major, channel-minor: p0c0, p0c1 … p0c(CH-1), p1c0 …. Transfer = `valid_in && ready_in`.
- States:
  - IDLE: `ready_in`=0. On `gap_en`=1, latch `mode`, clear counters, init accumulators, go ACCUM. Average init = 0. Max init = most-negative `ACC_W` value.
  - ACCUM: each transfer updates accumulator `ch_idx`.
    - Average: add sign-extended `in_data`.
    - Max: keep larger, signed compare.
    - Then `ch_idx` increments; at CH-1 it wraps to 0 and `dbg_sample_count` increments.
    - Transfer of the final sample (last position, channel CH-1) goes to DRAIN.
  - DRAIN: results emitted channel 0..CH-1. After channel CH-1 is accepted, go DONE.
    - Average result = `(acc + 2**(LOG2_N-1)) >>> LOG2_N`: round half up, arithmetic shift, then truncate to DATA_W. Fits by construction.
    - Max result = `acc[DATA_W-1:0]`.
  - DONE: `done`=1 for one cycle, go IDLE. A new frame starts only after `gap_en` has been seen low at least one cycle (edge-start, no auto-restart).
- Abort: `gap_en`=0 in ACCUM or DRAIN → IDLE next cycle. `valid_out` dropped, no `done`, partial data discarded.
- `mode` changes mid-frame are ignored.
- `valid_in` while not ACCUM is ignored (no transfer).

## Timing
- Reset (`rst`=0 at edge) forces IDLE. Zeroes `out_data`, `out_ch`, `valid_out`, `done`, `ready_in`, `dbg_accumulator`, `dbg_sample_count`, `ch_idx`, and all accumulators. Reset has priority over everything, including mid-frame.
- `gap_en` rises at edge e → `ready_in`=1 from cycle e+1.
- Full rate: one sample per cycle; frame takes `CH·2**LOG2_N` accepted transfers.
- Final transfer at edge t → DRAIN at t+1 (`ready_in`=0). First `valid_out` with `out_ch`=0 at t+2.
- Output register reloads when `!valid_out || ready_out`. Back-to-back results at one per cycle under constant `ready_out`.
- `out_data`/`out_ch` stable while `valid_out && !ready_out`.
- Last result accepted at edge a → `valid_out`=0 and `done`=1 during cycle a+1 → IDLE at a+2.
- `dbg_*` are registered, updated on the same edge as the accumulator/count.

## Test plan
- CH=2, LOG2_N=2, avg: ch0 {1,2,3,4}, ch1 {-1,-2,-3,-4}, constant `ready_out` → outputs (ch0, 3) then (ch1, -2), then `done` one cycle later.
- Same stream, `mode`=1 → (ch0, 4), (ch1, -1). All-negative channel {-9,-5,-7,-6} → -5.
- Default params, avg, all 4096×4 samples = 32767 → every result 32767; `dbg_sample_count`=4096 in DRAIN.
- Hold `ready_out`=0 for 5 cycles on first result → `out_data`/`out_ch` stable. Toggle `valid_in` randomly in ACCUM → results identical to full-rate run.
- Drop `gap_en` after 3 positions → IDLE, no `valid_out`/`done`. Re-raise → a fresh frame gives correct results. Assert `rst`=0 mid-DRAIN → all outputs 0 next cycle.
- Rounding: LOG2_N=1, samples {1,2} → 2; {-1,-2} → -1 (half up).

Source files
------------

// File: rtl/global_pool_mc_if.sv
// Streaming bus for global_pool_mc.
// Carries the sample input handshake (in_data/valid_in/ready_in) and the
// pooled-result output handshake (out_data/out_ch/valid_out/ready_out).
//   master : stream producer / result consumer (upstream + downstream side)
//   slave  : the pooling engine
interface global_pool_mc_if #(
  parameter int DATA_W = 16,
  parameter int CH     = 4
);
  localparam int CH_W = (CH > 1) ? $clog2(CH) : 1;

  logic signed [DATA_W-1:0] in_data;
  logic                     valid_in;
  logic                     ready_in;
  logic signed [DATA_W-1:0] out_data;
  logic [CH_W-1:0]          out_ch;
  logic                     valid_out;
  logic                     ready_out;

  modport master (
    output in_data, valid_in, ready_out,
    input  ready_in, out_data, out_ch, valid_out
  );

  modport slave (
    input  in_data, valid_in, ready_out,
    output ready_in, out_data, out_ch, valid_out
  );
endinterface

// File: rtl/global_pool_mc.sv
// Multi-channel global pooling engine.
// Consumes a channel-interleaved stream of 2**LOG2_N positions x CH channels,
// reduces every channel to its rounded average (mode=0) or maximum (mode=1)
// and drains the CH results one per accepted handshake.
// Ports:
//   clk, rst          : clock, synchronous active-low reset
//   gap_en            : level enable; rising edge in IDLE starts a frame,
//                       low during a frame aborts it
//   mode              : 0 = average, 1 = max, captured at frame start
//   bus               : sample input and result output handshakes
//   done              : one-cycle pulse after the last result is accepted
//   dbg_accumulator   : channel-0 accumulator
//   dbg_sample_count  : positions completed in the current frame
module global_pool_mc #(
  parameter int DATA_W = 16,
  parameter int CH     = 4,
  parameter int LOG2_N = 12,
  parameter int ACC_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               gap_en,
  input  logic               mode,
  global_pool_mc_if.slave    bus,
  output logic               done,
  output logic [ACC_W-1:0]   dbg_accumulator,
  output logic [16:0]        dbg_sample_count
);
  localparam int CH_W = (CH > 1) ? $clog2(CH) : 1;
  localparam logic [CH_W-1:0]         LAST_CH  = CH_W'(CH - 1);
  localparam logic [16:0]             LAST_POS = 17'((64'd1 << LOG2_N) - 64'd1);
  localparam logic signed [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] ROUND_K  = ACC_W'(1) << (LOG2_N - 1);

  if (ACC_W < DATA_W + LOG2_N) begin : g_acc_w_chk
    $error("global_pool_mc: ACC_W must be >= DATA_W + LOG2_N");
  end
  if (LOG2_N < 1 || LOG2_N > 16) begin : g_log2n_chk
    $error("global_pool_mc: LOG2_N must be in 1..16");
  end
  if (CH < 1) begin : g_ch_chk
    $error("global_pool_mc: CH must be >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN, S_DONE} state_t;

  state_t                   state, state_nxt;
  logic                     armed;       // gap_en seen low since the last start
  logic                     mode_max;
  logic                     issued_all;  // every channel has been loaded into the output register
  logic [CH_W-1:0]          ch_idx;      // accumulate channel, reused as drain channel
  logic [16:0]              pos_cnt;
  logic signed [ACC_W-1:0]  acc [CH];
  logic                     start, xfer, load, finish, abort;

  // Round half up, arithmetic shift, truncate to the sample width.
  function automatic logic signed [DATA_W-1:0] avg_round(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s;
    s = (a + ROUND_K) >>> LOG2_N;
    return s[DATA_W-1:0];
  endfunction

  function automatic logic signed [ACC_W-1:0] max_pick(input logic signed [ACC_W-1:0] a,
                                                        input logic signed [DATA_W-1:0] d);
    logic signed [ACC_W-1:0] e;
    e = ACC_W'(d);
    return (e > a) ? e : a;
  endfunction

  assign bus.ready_in     = (state == S_ACCUM);
  assign dbg_accumulator  = acc[0];
  assign dbg_sample_count = pos_cnt;

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    xfer      = 1'b0;
    load      = 1'b0;
    finish    = 1'b0;
    abort     = 1'b0;
    case (state)
      S_IDLE: begin
        if (gap_en && armed) begin
          start     = 1'b1;
          state_nxt = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (!gap_en) begin
          abort     = 1'b1;
          state_nxt = S_IDLE;
        end else if (bus.valid_in) begin
          xfer = 1'b1;
          if (ch_idx == LAST_CH && pos_cnt == LAST_POS) state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!gap_en) begin
          abort     = 1'b1;
          state_nxt = S_IDLE;
        end else if (!bus.valid_out || bus.ready_out) begin
          if (!issued_all) begin
            load = 1'b1;
          end else if (bus.valid_out) begin
            finish    = 1'b1;
            state_nxt = S_DONE;
          end
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      armed         <= 1'b0;
      mode_max      <= 1'b0;
      issued_all    <= 1'b0;
      ch_idx        <= '0;
      pos_cnt       <= '0;
      for (int i = 0; i < CH; i++) acc[i] <= '0;
      bus.out_data  <= '0;
      bus.out_ch    <= '0;
      bus.valid_out <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= finish;
      if (!gap_en)    armed <= 1'b1;
      else if (start) armed <= 1'b0;

      if (start) begin
        mode_max   <= mode;
        issued_all <= 1'b0;
        ch_idx     <= '0;
        pos_cnt    <= '0;
        for (int i = 0; i < CH; i++) acc[i] <= mode ? ACC_MIN : '0;
      end

      if (xfer) begin
        acc[ch_idx] <= mode_max ? max_pick(acc[ch_idx], bus.in_data)
                                : acc[ch_idx] + ACC_W'(bus.in_data);
        if (ch_idx == LAST_CH) begin
          ch_idx  <= '0;
          pos_cnt <= pos_cnt + 17'd1;
        end else begin
          ch_idx <= ch_idx + 1'b1;
        end
      end

      if (load) begin
        bus.out_data  <= mode_max ? acc[ch_idx][DATA_W-1:0] : avg_round(acc[ch_idx]);
        bus.out_ch    <= ch_idx;
        bus.valid_out <= 1'b1;
        if (ch_idx == LAST_CH) issued_all <= 1'b1;
        else                   ch_idx     <= ch_idx + 1'b1;
      end

      if (finish || abort) bus.valid_out <= 1'b0;
    end
  end
endmodule
